div16by8_seq: RTL and testbench
===============================

Name: div16by8_seq

Overview:
- Sequential unsigned divider: 2W-bit dividend by W-bit divisor, giving a W-bit quotient and a W-bit remainder. With W=8 it is the inverse of the team's 8x8 array multiplier: given y=a*b and b, it recovers a.
- Restoring algorithm, one quotient bit per clock.
- Valid/ready handshake on both the input and output side, so it sits between the arithmetic datapath and its consumer.

Parameters:
- W, 8, divisor/quotient/remainder width; dividend width is 2W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- dividend  input  2W  unsigned dividend.
- divisor  input  W  unsigned divisor.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder.
- dbz  output  1  divide-by-zero flag, qualified by out_valid.
- ovf  output  1  quotient-overflow flag, qualified by out_valid.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: when rst_n is low, state goes to IDLE; out_valid, quotient, remainder, dbz, ovf and the iteration counter all go to 0. in_ready=1 (decoded from IDLE); inputs are ignored while rst_n is low.
- States are IDLE, CALC and DONE.
- IDLE: in_ready=1. Acceptance happens on an edge where in_valid=1. At that edge the block registers the divisor, then branches:
  - divisor==0 -> DONE with dbz=1, ovf=0.
  - else if dividend[2W-1:W] >= divisor -> DONE with ovf=1, dbz=0.
  - else -> CALC. Load partial remainder R (W+1 bits) = {0, dividend[2W-1:W]}, shift register Q = dividend[W-1:0], counter = 0.
- CALC, each cycle:
  - Shift {R,Q} left by 1.
  - If R >= divisor: R = R - divisor and Q[0] = 1; else Q[0] = 0.
  - counter increments; after W iterations go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1. Normal result: quotient=Q, remainder=R[W-1:0].
  - Error result (dbz or ovf): quotient = all ones, remainder = dividend[W-1:0].
  - Outputs and flags stay stable until out_valid&&out_ready, then go to IDLE on that edge. out_valid drops the next cycle.
  - in_ready=0 in DONE; no overlap of acceptance and delivery.
- Latency, counted from the acceptance edge:
  - normal: out_valid high after W+1 edges (W=8: 9 cycles);
  - error: out_valid high after 1 edge.
- Throughput: at most one operation per W+2 cycles (normal path, out_ready tied high).
- Invariant on normal results: quotient*divisor + remainder == dividend, and remainder < divisor.
- dbz takes priority over ovf; they are never both 1.
- Reset asserted mid-CALC or mid-DONE aborts the operation and discards the result. After release the block is in IDLE, and the next operation is unaffected.
- Operand changes while in CALC or DONE are ignored, because operands are registered at acceptance.

Optional Feature:
- Macro DIV_SELFCHECK_EN.
- When defined:
  - Extra output port chk_err (1 bit, reset 0).
  - In DONE on the normal path, chk_err=1 if quotient*divisor + remainder != registered dividend. The product is computed combinationally at W x W.
  - chk_err is held with the result and forced to 0 for dbz/ovf results.
- When undefined: the chk_err port and the checking logic are absent; all other behaviour is identical.

Test Plan:
- dividend=0x3039 (12345), divisor=0x64 (100), out_ready=1 -> quotient=0x7B, remainder=0x2D, dbz=ovf=0, out_valid rises 9 cycles after acceptance, high for 1 cycle.
- dividend=0xFE01, divisor=0xFF -> quotient=0xFF, remainder=0x00 (255*255 round-trip from the multiplier).
- dividend=0x1234, divisor=0x00 -> dbz=1, ovf=0, quotient=0xFF, remainder=0x34, out_valid 1 cycle after acceptance.
- dividend=0x1234, divisor=0x12 -> ovf=1, dbz=0, quotient=0xFF, remainder=0x34; with divisor=0x13 instead -> quotient=0xF5, remainder=0x05, ovf=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> one transfer, then IDLE with in_ready=1.
- Assert rst_n=0 at the 4th CALC cycle -> immediately out_valid=0, in_ready=1. After release, 0x3039/0x64 -> 0x7B r 0x2D. With DIV_SELFCHECK_EN defined, chk_err=0 throughout.

Source files
------------

// File: rtl/div16by8_seq_if.sv
// Operand/result handshake bundle for div16by8_seq.
// chk_err is present only when DIV_SELFCHECK_EN is defined.
interface div16by8_seq_if #(
    parameter int W = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           dbz;
    logic           ovf;
`ifdef DIV_SELFCHECK_EN
    logic           chk_err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf, chk_err
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf, chk_err
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf
    );
`endif
endinterface

// File: rtl/div16by8_seq.sv
// Sequential restoring divider, 2W/W bits, one quotient bit per clock.
// DIV_SELFCHECK_EN adds chk_err: q*d+r cross-check of normal results.
//
// state | meaning
// IDLE  | in_ready=1, operands accepted on in_valid
// CALC  | W restoring iterations on {R,Q}
// DONE  | result held with out_valid=1 until out_ready
module div16by8_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    div16by8_seq_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   dvs_q;
    logic [CW-1:0]  cnt;
    logic           dbz_q, ovf_q;
    logic [W:0]     rem_sh;
    logic           rem_ge;
    logic           accept, last_iter, div_zero, div_ovf;

    // R is kept W bits wide: after every restore it is below the divisor,
    // so its top bit only exists transiently in the shifted value.
    assign rem_sh    = {rem_q, quo_q[W-1]};
    assign rem_ge    = rem_sh >= {1'b0, dvs_q};
    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_iter = (state == CALC) && (cnt == CW'(W - 1));
    assign div_zero  = (bus.divisor == '0);
    assign div_ovf   = (bus.dividend[2*W-1:W] >= bus.divisor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = (div_zero || div_ovf) ? DONE : CALC;
            CALC: if (last_iter) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            dvs_q <= bus.divisor;
            cnt   <= '0;
            dbz_q <= div_zero;
            ovf_q <= !div_zero && div_ovf;
            if (div_zero || div_ovf) begin
                quo_q <= '1;
                rem_q <= bus.dividend[W-1:0];
            end else begin
                quo_q <= bus.dividend[W-1:0];
                rem_q <= bus.dividend[2*W-1:W];
            end
        end else if (state == CALC) begin
            cnt   <= cnt + CW'(1);
            quo_q <= {quo_q[W-2:0], rem_ge};
            rem_q <= rem_ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

`ifdef DIV_SELFCHECK_EN
    logic [2*W-1:0] dvd_q;
    logic [2*W-1:0] recon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dvd_q <= '0;
        else if (accept) dvd_q <= bus.dividend;
    end

    assign recon       = ({{W{1'b0}}, quo_q} * {{W{1'b0}}, dvs_q}) + {{W{1'b0}}, rem_q};
    assign bus.chk_err = (state == DONE) && !dbz_q && !ovf_q && (recon != dvd_q);
`endif
endmodule

// File: tb/tb_div16by8_seq.sv
// Self-checking bench for div16by8_seq: directed cases plus random operands
// compared against a plain-arithmetic division model.
module tb_div16by8_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div16by8_seq_if #(.W(8)) bus ();

    div16by8_seq #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] dvd, input logic [7:0] dvs,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
        int quot;
        dz = 1'b0;
        ov = 1'b0;
        q  = 8'h00;
        r  = 8'h00;
        if (dvs == 8'h00) begin
            dz = 1'b1;
        end else begin
            quot = int'(dvd) / int'(dvs);
            if (quot > 255) ov = 1'b1;
            else begin
                q = quot[7:0];
                r = 8'(int'(dvd) % int'(dvs));
            end
        end
        if (dz || ov) begin
            q = 8'hFF;
            r = dvd[7:0];
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                                input logic ez, input logic eo);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 1);
        check({tag, ".in_ready"},  32'(bus.in_ready), 0);
        check({tag, ".quotient"},  32'(bus.quotient), 32'(eq));
        check({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, ".dbz"},       32'(bus.dbz), 32'(ez));
        check({tag, ".ovf"},       32'(bus.ovf), 32'(eo));
`ifdef DIV_SELFCHECK_EN
        check({tag, ".chk_err"},   32'(bus.chk_err), 0);
`endif
    endtask

    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input int hold);
        logic [7:0] eq, er;
        logic       ez, eo;
        int         lat, wt;
        model(dvd, dvs, eq, er, ez, eo);
        bus.out_ready = (hold == 0);
        wt = 0;
        while (!bus.in_ready && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        check({tag, ".idle"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), (ez || eo) ? 1 : 9);
        check_result(tag, eq, er, ez, eo);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
            @(posedge clk); #1;
            check_result({tag, ".hold"}, eq, er, ez, eo);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".drop_valid"}, 32'(bus.out_valid), 0);
        check({tag, ".back_idle"},  32'(bus.in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dvd;
        logic [7:0]  dvs, a, r;
        int          mode;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #1;
        check("rst.in_ready",  32'(bus.in_ready), 1);
        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.quotient",  32'(bus.quotient), 0);
        check("rst.remainder", 32'(bus.remainder), 0);
        check("rst.dbz",       32'(bus.dbz), 0);
        check("rst.ovf",       32'(bus.ovf), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("d12345",   16'h3039, 8'h64, 0);
        run_op("d255sq",   16'hFE01, 8'hFF, 0);
        run_op("dbz",      16'h1234, 8'h00, 0);
        run_op("ovf_eq",   16'h1234, 8'h12, 0);
        run_op("no_ovf",   16'h1234, 8'h13, 0);
        run_op("bp_norm",  16'h3039, 8'h64, 5);
        run_op("bp_err",   16'hABCD, 8'h00, 5);
        run_op("zero_dvd", 16'h0000, 8'h01, 1);
        run_op("max_q",    16'h00FF, 8'h01, 0);

        // Abort in the 4th CALC cycle
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'h3039;
        bus.divisor   = 8'h64;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort.out_valid", 32'(bus.out_valid), 0);
        check("abort.in_ready",  32'(bus.in_ready), 1);
        check("abort.quotient",  32'(bus.quotient), 0);
        @(posedge clk); #1;
        check("abort.hold_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 16'h3039, 8'h64, 0);

        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 3));
            dvs  = 8'($urandom_range(1, 255));
            case (mode)
                0: begin
                    a   = 8'($urandom);
                    r   = 8'($urandom_range(0, int'(dvs) - 1));
                    dvd = 16'(int'(a) * int'(dvs) + int'(r));
                end
                1: dvd = 16'($urandom);
                2: begin
                    dvs = 8'h00;
                    dvd = 16'($urandom);
                end
                default: begin
                    dvs = 8'($urandom);
                    dvd = 16'($urandom);
                end
            endcase
            run_op("rand", dvd, dvs, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
